// File: rtl/hazard_unit_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Contents: forwarding select encodings (FWD_RF/FWD_WB/FWD_MEM) and the
// long-operation FSM state enum (IDLE/BUSY).
package hazard_pkg;

   localparam logic [1:0] FWD_RF  = 2'b00;   // operand from register file
   localparam logic [1:0] FWD_WB  = 2'b01;   // operand from Writeback result
   localparam logic [1:0] FWD_MEM = 2'b10;   // operand from Memory ALU result

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } hz_state_e;

endpackage

// File: rtl/hazard_unit_if.sv
// Bundle of pipeline-status inputs and hazard-control outputs.
// master: pipeline side (drives stage indices/controls, receives selects and
// stall/flush). slave: hazard unit (the reverse directions).
interface hazard_unit_if #(
   parameter int REG_ADDR_W = 5
);
   logic [REG_ADDR_W-1:0] Rs1D, Rs2D;
   logic [REG_ADDR_W-1:0] Rs1E, Rs2E;
   logic [REG_ADDR_W-1:0] RdE, RdM, RdW;
   logic                  RegWriteE, RegWriteM, RegWriteW;
   logic                  LoadE;
   logic                  PCSrcE;
   logic                  LongOpE;
   logic [1:0]            ForwardAE, ForwardBE;
   logic                  StallF, StallD, StallE;
   logic                  FlushD, FlushE, FlushM;
   logic                  ExecBusy;

   modport master (
      output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
      output RegWriteE, RegWriteM, RegWriteW, LoadE, PCSrcE, LongOpE,
      input  ForwardAE, ForwardBE, StallF, StallD, StallE,
      input  FlushD, FlushE, FlushM, ExecBusy
   );

   modport slave (
      input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
      input  RegWriteE, RegWriteM, RegWriteW, LoadE, PCSrcE, LongOpE,
      output ForwardAE, ForwardBE, StallF, StallD, StallE,
      output FlushD, FlushE, FlushM, ExecBusy
   );
endinterface

// File: rtl/hazard_unit_fwd_sel.sv
// Forwarding select for one Execute-stage source operand.
// Ports: rs_i (Execute source index), rd_m_i/reg_write_m_i (Memory producer),
// rd_w_i/reg_write_w_i (Writeback producer), sel_o (2-bit operand select).
module fwd_sel
   import hazard_pkg::*;
#(
   parameter int REG_ADDR_W = 5
) (
   input  logic [REG_ADDR_W-1:0] rs_i,
   input  logic [REG_ADDR_W-1:0] rd_m_i,
   input  logic [REG_ADDR_W-1:0] rd_w_i,
   input  logic                  reg_write_m_i,
   input  logic                  reg_write_w_i,
   output logic [1:0]            sel_o
);

   logic hit_m;
   logic hit_w;

   // x0 is hardwired zero, so a write to it never produces a value to forward.
   assign hit_m = reg_write_m_i && (rd_m_i != '0) && (rd_m_i == rs_i);
   assign hit_w = reg_write_w_i && (rd_w_i != '0) && (rd_w_i == rs_i);

   // Memory holds the younger result, so it takes priority over Writeback.
   always_comb begin
      sel_o = FWD_RF;
      if (hit_m) begin
         sel_o = FWD_MEM;
      end else if (hit_w) begin
         sel_o = FWD_WB;
      end
   end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: forwarding selects, load-use / RAW stalls,
// branch flushes and a busy FSM that holds the front end during MUL/DIV.
// Ports: clk, rst (sync, active-high), hz (hazard_unit_if.slave bundle).
// Build option: FORWARDING_EN enables operand forwarding with a load-use
// stall; without it selects stay at register file and any RAW dependency
// on Execute/Memory stalls Decode until the producer reaches Writeback.
module hazard_unit
   import hazard_pkg::*;
#(
   parameter int LONG_LAT   = 4,   // cycles a long op occupies Execute, 2..16
   parameter int REG_ADDR_W = 5
) (
   input  logic   clk,
   input  logic   rst,
   hazard_unit_if.slave hz
);

   localparam int                CNT_W    = $clog2(LONG_LAT);
   localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(LONG_LAT - 2);

   hz_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;

   logic [1:0] sel_a, sel_b;
   logic       data_hazard;
   logic       busy;
   logic       unused_inputs;

`ifdef FORWARDING_EN
   fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
      .rs_i          (hz.Rs1E),
      .rd_m_i        (hz.RdM),
      .rd_w_i        (hz.RdW),
      .reg_write_m_i (hz.RegWriteM),
      .reg_write_w_i (hz.RegWriteW),
      .sel_o         (sel_a)
   );

   fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
      .rs_i          (hz.Rs2E),
      .rd_m_i        (hz.RdM),
      .rd_w_i        (hz.RdW),
      .reg_write_m_i (hz.RegWriteM),
      .reg_write_w_i (hz.RegWriteW),
      .sel_o         (sel_b)
   );

   // A load's data is not available for forwarding until after Memory,
   // so a consumer directly behind it in Decode must wait one cycle.
   assign data_hazard = hz.LoadE && (hz.RdE != '0) &&
                        ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));

   assign unused_inputs = hz.RegWriteE;
`else
   logic raw_e;
   logic raw_m;

   assign sel_a = FWD_RF;
   assign sel_b = FWD_RF;

   // Without forwarding a consumer waits until its producer is in Writeback;
   // the register file writes before reading, so Writeback needs no stall.
   assign raw_e = hz.RegWriteE && (hz.RdE != '0) &&
                  ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
   assign raw_m = hz.RegWriteM && (hz.RdM != '0) &&
                  ((hz.RdM == hz.Rs1D) || (hz.RdM == hz.Rs2D));
   assign data_hazard = raw_e || raw_m;

   assign unused_inputs = ^{hz.Rs1E, hz.Rs2E, hz.RdW, hz.RegWriteW, hz.LoadE};
`endif

   // ExecBusy covers the capture cycle in IDLE plus every BUSY cycle except
   // the last, where the op is released into Memory.
   assign busy = ((state_q == IDLE) && hz.LongOpE) ||
                 ((state_q == BUSY) && (cnt_q != '0));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (hz.LongOpE) begin
               state_d = BUSY;
               cnt_d   = CNT_LOAD;
            end
         end
         BUSY: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   logic [1:0] fwd_a, fwd_b;
   logic       stall_f, stall_d, stall_e;
   logic       flush_d, flush_e, flush_m;
   logic       exec_busy;

   // Priority: reset, then long-op hold, then branch flush, then data stall.
   // A taken branch kills the stalled consumer anyway, so flush beats stall.
   always_comb begin
      fwd_a     = sel_a;
      fwd_b     = sel_b;
      stall_f   = 1'b0;
      stall_d   = 1'b0;
      stall_e   = 1'b0;
      flush_d   = 1'b0;
      flush_e   = 1'b0;
      flush_m   = 1'b0;
      exec_busy = 1'b0;
      if (rst) begin
         fwd_a   = FWD_RF;
         fwd_b   = FWD_RF;
         flush_d = 1'b1;
         flush_e = 1'b1;
         flush_m = 1'b1;
      end else if (busy) begin
         // Hold F/D/E and feed bubbles into Memory while the op iterates.
         stall_f   = 1'b1;
         stall_d   = 1'b1;
         stall_e   = 1'b1;
         flush_m   = 1'b1;
         exec_busy = 1'b1;
      end else if (hz.PCSrcE) begin
         flush_d = 1'b1;
         flush_e = 1'b1;
      end else if (data_hazard) begin
         stall_f = 1'b1;
         stall_d = 1'b1;
         flush_e = 1'b1;
      end
   end

   assign hz.ForwardAE = fwd_a;
   assign hz.ForwardBE = fwd_b;
   assign hz.StallF    = stall_f;
   assign hz.StallD    = stall_d;
   assign hz.StallE    = stall_e;
   assign hz.FlushD    = flush_d;
   assign hz.FlushE    = flush_e;
   assign hz.FlushM    = flush_m;
   assign hz.ExecBusy  = exec_busy;

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the five-stage core. Watches register indices and control bits in the Decode, Execute, Memory and Writeback stages. Drives the operand-forwarding selects of the Execute stage and the stall/flush controls of the pipeline registers. Sequences multi-cycle Execute operations (MUL/DIV) through a small busy FSM that holds the front of the pipeline until the operation completes.

## Interface
Parameters:
- LONG_LAT, default 4: total cycles a long operation occupies Execute; legal range 2..16.
- REG_ADDR_W, default 5: register index width.

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  pipeline clock, all state on rising edge
- rst  input  1  synchronous active-high reset
- Rs1D, Rs2D  input  REG_ADDR_W  source indices in Decode
- Rs1E, Rs2E  input  REG_ADDR_W  source indices in Execute
- RdE, RdM, RdW  input  REG_ADDR_W  destination indices in Execute/Memory/Writeback
- RegWriteE, RegWriteM, RegWriteW  input  1  destination write enable per stage
- LoadE  input  1  instruction in Execute is a load (result from data memory)
- PCSrcE  input  1  branch/jump taken, resolved in Execute
- LongOpE  input  1  instruction in Execute is a multi-cycle operation
- ForwardAE, ForwardBE  output  2  operand select: 00 register file, 01 Writeback result, 10 Memory ALU result
- StallF, StallD, StallE  output  1  hold PC / IF-ID / ID-EX registers
- FlushD, FlushE, FlushM  output  1  load bubble into IF-ID / ID-EX / EX-MEM
- ExecBusy  output  1  long operation in progress

## Operation
- Forwarding, per operand X in {1,2}:
  - 10 if RegWriteM and RdM!=0 and RdM==RsXE;
  - else 01 if RegWriteW and RdW!=0 and RdW==RsXE;
  - else 00. Memory has priority over Writeback.
- Load-use: LoadE and RdE!=0 and (RdE==Rs1D or RdE==Rs2D) -> StallF=StallD=1, FlushE=1 for one cycle.
- Branch: PCSrcE -> FlushD=FlushE=1. A branch coinciding with load-use: flush wins, stalls deasserted.
- Long-op FSM, states IDLE, BUSY; counter cnt, width $clog2(LONG_LAT).
  - IDLE with LongOpE: StallF=StallD=StallE=1, FlushM=1, ExecBusy=1; load cnt=LONG_LAT-2; go to BUSY. The multi-cycle unit captures its operands in this cycle.
  - BUSY with cnt!=0: same outputs; cnt decrements.
  - BUSY with cnt==0: stalls and FlushM released, ExecBusy=0; go to IDLE. The op advances to Memory on this edge.
  - The op therefore occupies Execute for exactly LONG_LAT cycles.
  - While ExecBusy=1, load-use and branch outputs are suppressed. A long op is never a load or a branch.
- The register file writes before it reads in the same cycle, so a Writeback destination never needs a Decode stall.

## Timing
- Forward selects, stalls and flushes are combinational from inputs and FSM state; the FSM and cnt are registered.
- While rst=1: ForwardAE=ForwardBE=00, all stalls 0, FlushD=FlushE=FlushM=1, ExecBusy=0.
- On the next edge after rst: state IDLE, cnt=0.
- Reset asserted during BUSY aborts the op: IDLE after the edge, no residual stall.
- Back-to-back long ops: the second enters Execute the cycle after release and starts in IDLE. There is no dead cycle between them.

## Configuration
- FORWARDING_EN defined: behaviour as above.
- FORWARDING_EN undefined:
  - ForwardAE=ForwardBE=00 always.
  - RAW stall: any (RegWriteE and RdE!=0 and RdE in {Rs1D,Rs2D}) or (RegWriteM and RdM!=0 and RdM in {Rs1D,Rs2D}) -> StallF=StallD=1, FlushE=1, repeated each cycle until the producer reaches Writeback.
  - This replaces the load-use rule. Branch and long-op rules are unchanged.

## Structure
- hazard_pkg holds:
  - forward select constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10;
  - the FSM state enum {IDLE, BUSY}.
- Sub-module fwd_sel computes one operand's select and is instantiated twice (Rs1E, Rs2E). The FSM stays in hazard_unit.

## Test plan
- RegWriteM=1, RdM=5, Rs1E=5, and RegWriteW=1, RdW=5 -> ForwardAE=10. With RdM=0 -> ForwardAE=01.
- LoadE=1, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for one cycle. Same cycle with PCSrcE=1 -> FlushD=FlushE=1, StallF=StallD=0.
- LongOpE=1 with LONG_LAT=4 -> StallE=ExecBusy=1 for 3 cycles, released in the 4th; second LongOpE next cycle -> another 4-cycle window with no gap.
- rst pulsed in the 2nd BUSY cycle -> stalls 0 one cycle after rst deasserts, state IDLE.
- FORWARDING_EN undefined: RegWriteE=1, RdE=3, Rs1D=3 -> stall 2 cycles (producer in E then M), released when the producer reaches Writeback; ForwardAE stays 00.
- Rd=0 destinations with matching sources -> no forward, no stall.
